// File: rtl/ov7670_power_sequencer_pkg.sv
// Shared types and constants for the OV7670 power-up sequencer.
// Holds the FSM state encoding, the default dwell counts and the lock-loss saturation limit.
package ov7670_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    DEBOUNCE   = 3'd1,
    PWDN_HOLD  = 3'd2,
    RESET_HOLD = 3'd3,
    SETTLE     = 3'd4,
    READY      = 3'd5
  } pwr_state_t;

  // 1 ms at the 50 MHz reference clock.
  localparam int DEF_LOCK_STABLE_CYCLES = 50000;
  localparam int DEF_PWDN_CYCLES        = 50000;
  localparam int DEF_RESET_CYCLES       = 50000;
  localparam int DEF_SETTLE_CYCLES      = 50000;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

  function automatic int dwell_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ov7670_power_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
// Each bit is synchronized independently; only use it for quasi-static signals.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ov7670_power_sequencer.sv
// Sequences XCLK, PWDN and RESET# of the OV7670 after the camera PLL locks,
// and drops the sensor back to its safe state whenever lock is lost.
module ov7670_power_sequencer
  import ov7670_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int PWDN_CYCLES        = DEF_PWDN_CYCLES,
  parameter int RESET_CYCLES       = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
  parameter int CNT_W              = $clog2(dwell_max(LOCK_STABLE_CYCLES, PWDN_CYCLES,
                                                      RESET_CYCLES, SETTLE_CYCLES))
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       restart,
  output logic       xclk_en,
  output logic       cam_pwdn,
  output logic       cam_reset_n,
  output logic       cam_ready,
  output logic [7:0] lock_loss_count
);

  if (LOCK_STABLE_CYCLES < 1 || PWDN_CYCLES < 1 || RESET_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_dwell
    $error("ov7670_power_sequencer: every dwell parameter must be at least 1");
  end

  // All dwells of 1 give CNT_W of 0; keep at least one counter bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  logic          locked_s;
  pwr_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    loss_cnt_reg;
  int            dwell_last;
  logic          dwell_done;
  logic          timed;
  logic          lock_lost;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    dwell_last = 0;
    timed      = 1'b1;
    case (state_reg)
      DEBOUNCE:   dwell_last = LOCK_STABLE_CYCLES - 1;
      PWDN_HOLD:  dwell_last = PWDN_CYCLES - 1;
      RESET_HOLD: dwell_last = RESET_CYCLES - 1;
      SETTLE:     dwell_last = SETTLE_CYCLES - 1;
      default:    timed = 1'b0;
    endcase
    dwell_done = (int'(cnt_reg) == dwell_last);
    // Losing lock before the sensor is clocked is not counted as a loss.
    lock_lost  = !locked_s && (state_reg inside {PWDN_HOLD, RESET_HOLD, SETTLE, READY});

    state_next = state_reg;
    if (lock_lost) begin
      state_next = WAIT_LOCK;
    end else begin
      case (state_reg)
        WAIT_LOCK:  if (locked_s) state_next = DEBOUNCE;
        DEBOUNCE:   if (!locked_s) state_next = WAIT_LOCK;
                    else if (dwell_done) state_next = PWDN_HOLD;
        PWDN_HOLD:  if (dwell_done) state_next = RESET_HOLD;
        RESET_HOLD: if (dwell_done) state_next = SETTLE;
        SETTLE:     if (dwell_done) state_next = READY;
        READY:      if (restart) state_next = PWDN_HOLD;
        default:    state_next = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg    <= WAIT_LOCK;
      cnt_reg      <= '0;
      loss_cnt_reg <= '0;
      xclk_en      <= 1'b0;
      cam_pwdn     <= 1'b1;
      cam_reset_n  <= 1'b0;
      cam_ready    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg || !timed) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (lock_lost && loss_cnt_reg != LOCK_LOSS_MAX) begin
        loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
      // Outputs decode the next state so pins move on the same edge as the state.
      xclk_en     <= state_next inside {PWDN_HOLD, RESET_HOLD, SETTLE, READY};
      cam_pwdn    <= state_next inside {WAIT_LOCK, DEBOUNCE, PWDN_HOLD};
      cam_reset_n <= state_next inside {SETTLE, READY};
      cam_ready   <= (state_next == READY);
    end
  end

  assign lock_loss_count = loss_cnt_reg;

endmodule

// File: tb/tb_ov7670_power_sequencer.sv
// Self-checking bench: a phase-arithmetic model of the power-up sequence is compared
// against the sequencer every cycle, with literal edge expectations pinning the model.
module tb_ov7670_power_sequencer;

  localparam int L   = 4;
  localparam int P   = 3;
  localparam int R   = 5;
  localparam int S   = 2;
  localparam int TOT = L + P + R + S;

  logic       refclk  = 1'b0;
  logic       rst     = 1'b1;
  logic       locked  = 1'b0;
  logic       restart = 1'b0;
  logic       xclk_en;
  logic       cam_pwdn;
  logic       cam_reset_n;
  logic       cam_ready;
  logic [7:0] lock_loss_count;

  int errors = 0;
  int checks = 0;

  ov7670_power_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .PWDN_CYCLES        (P),
    .RESET_CYCLES       (R),
    .SETTLE_CYCLES      (S)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .locked          (locked),
    .restart         (restart),
    .xclk_en         (xclk_en),
    .cam_pwdn        (cam_pwdn),
    .cam_reset_n     (cam_reset_n),
    .cam_ready       (cam_ready),
    .lock_loss_count (lock_loss_count)
  );

  always #10 refclk = ~refclk;

  // Model: the sequence is a timeline measured from the edge DEBOUNCE began (m_org).
  int   edge_cnt = 0;
  bit   m_valid  = 0;
  bit   m_s1, m_s2, m_act;
  int   m_org;
  int   m_cnt;

  initial begin
    bit ls;
    int n;
    int p;
    forever begin
      @(posedge refclk);
      n = edge_cnt;
      if (rst) begin
        m_s1 = 0; m_s2 = 0; m_act = 0; m_cnt = 0; m_valid = 1;
      end else begin
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        p    = (n - 1) - m_org;
        if (!m_act) begin
          if (ls) begin m_act = 1; m_org = n; end
        end else if (!ls) begin
          if (p >= L && m_cnt < 255) m_cnt = m_cnt + 1;
          m_act = 0;
        end else if (p >= TOT && restart) begin
          m_org = n - L;
        end
      end
      edge_cnt = edge_cnt + 1;
    end
  end

  function automatic logic [3:0] model_outs();
    int q;
    q = (edge_cnt - 1) - m_org;
    if (!m_act || q < L)  return 4'b0100;
    if (q < L + P)        return 4'b1100;
    if (q < L + P + R)    return 4'b1000;
    if (q < TOT)          return 4'b1010;
    return 4'b1011;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h after edge %0d", name, act, exp, edge_cnt - 1);
    end
  endtask

  initial begin
    forever begin
      @(negedge refclk);
      if (m_valid) begin
        chk("model_pins", {28'd0, xclk_en, cam_pwdn, cam_reset_n, cam_ready}, {28'd0, model_outs()});
        chk("model_loss_count", {24'd0, lock_loss_count}, m_cnt);
      end
    end
  end

  task automatic wait_after(input int e);
    while (edge_cnt < e + 1) @(negedge refclk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, m;
    // Reset state
    repeat (3) @(negedge refclk);
    chk("rst_xclk_en", xclk_en, 0);
    chk("rst_cam_pwdn", cam_pwdn, 1);
    chk("rst_cam_reset_n", cam_reset_n, 0);
    chk("rst_cam_ready", cam_ready, 0);
    chk("rst_loss_count", lock_loss_count, 0);

    // Scenario 1: bring-up timing from lock
    rst = 1'b0; locked = 1'b1; k = edge_cnt;
    wait_after(k + 5);  chk("s1_xclk_pre", xclk_en, 0);
    wait_after(k + 6);  chk("s1_xclk_on", xclk_en, 1); chk("s1_pwdn_hold", cam_pwdn, 1);
    wait_after(k + 8);  chk("s1_pwdn_still", cam_pwdn, 1);
    wait_after(k + 9);  chk("s1_pwdn_fall", cam_pwdn, 0); chk("s1_rstn_low", cam_reset_n, 0);
    wait_after(k + 13); chk("s1_rstn_pre", cam_reset_n, 0);
    wait_after(k + 14); chk("s1_rstn_rise", cam_reset_n, 1); chk("s1_ready_pre", cam_ready, 0);
    wait_after(k + 15); chk("s1_ready_pre2", cam_ready, 0);
    wait_after(k + 16); chk("s1_ready_rise", cam_ready, 1);

    // Scenario 3: lock loss from READY, then re-lock
    wait_after(k + 20);
    locked = 1'b0; j = edge_cnt;
    wait_after(j + 1); chk("s3_ready_hold", cam_ready, 1);
    wait_after(j + 2);
    chk("s3_safe_ready", cam_ready, 0); chk("s3_safe_xclk", xclk_en, 0);
    chk("s3_safe_pwdn", cam_pwdn, 1);   chk("s3_safe_rstn", cam_reset_n, 0);
    chk("s3_loss_count", lock_loss_count, 1);
    wait_after(j + 5);
    locked = 1'b1; k = edge_cnt;
    wait_after(k + 15); chk("s3_relock_pre", cam_ready, 0);
    wait_after(k + 16); chk("s3_relock_ready", cam_ready, 1);

    // Scenario 5: restart from READY, ignored restart in SETTLE, loss beats restart
    wait_after(k + 18);
    m = edge_cnt; pulse_restart();
    chk("s5_restart_ready", cam_ready, 0); chk("s5_restart_pwdn", cam_pwdn, 1);
    chk("s5_restart_xclk", xclk_en, 1);
    wait_after(m + 8); pulse_restart();
    chk("s5_settle_ignore", cam_ready, 0);
    wait_after(m + 10); chk("s5_ready_again", cam_ready, 1);
    wait_after(m + 14);
    locked = 1'b0; j = edge_cnt;
    wait_after(j + 1); pulse_restart();
    chk("s5_both_xclk", xclk_en, 0); chk("s5_both_ready", cam_ready, 0);
    chk("s5_both_count", lock_loss_count, 2);

    // Scenario 6: reset during RESET_HOLD
    wait_after(j + 4);
    locked = 1'b1; k = edge_cnt;
    wait_after(k + 10);
    chk("s6_in_reset_hold", {cam_pwdn, cam_reset_n, xclk_en}, 3'b001);
    rst = 1'b1; @(negedge refclk);
    chk("s6_xclk", xclk_en, 0); chk("s6_pwdn", cam_pwdn, 1);
    chk("s6_rstn", cam_reset_n, 0); chk("s6_ready", cam_ready, 0);
    chk("s6_count", lock_loss_count, 0);

    // Scenario 2: short lock glitch never leaves DEBOUNCE
    locked = 1'b0; repeat (3) @(negedge refclk);
    rst = 1'b0; locked = 1'b1; k = edge_cnt;
    wait_after(k + 2); locked = 1'b0;
    wait_after(k + 25);
    chk("s2_xclk", xclk_en, 0); chk("s2_count", lock_loss_count, 0);

    // Scenario 4: 300 lock losses from READY saturate the counter
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1; k = edge_cnt;
      wait_after(k + 17);
      if (i == 0) chk("s4_ready_first", cam_ready, 1);
      locked = 1'b0; j = edge_cnt;
      wait_after(j + 3);
      if (i == 0) chk("s4_count_first", lock_loss_count, 1);
    end
    chk("s4_saturated", lock_loss_count, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ov7670_power_sequencer.md
# ov7670_power_sequencer

Brings the OV7670 camera up in a safe order once the 10 MHz camera PLL has locked. It runs on the 50 MHz board reference clock and watches the PLL `locked` output. It gates XCLK to the sensor and drives the sensor's PWDN and RESET# pins through a timed sequence. When the sensor is safe to program, it raises `cam_ready`, which releases the SCCB register-configuration stage. On PLL lock loss it returns the sensor to the safe state and, once the PLL re-locks, repeats the whole sequence.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, 50000: `locked` must stay high this many cycles (1 ms) before the sequence starts.
- `PWDN_CYCLES`, 50000: dwell with XCLK running, PWDN high and RESET# low.
- `RESET_CYCLES`, 50000: dwell with PWDN low and RESET# low.
- `SETTLE_CYCLES`, 50000: dwell after RESET# release before `cam_ready`.
- `CNT_W`, `$clog2` of the largest of the four dwell parameters: width of the dwell counter.
- All four dwell parameters must be ≥1. Elaboration fails otherwise.

Ports:
- `refclk`, in, 1: the single clock (50 MHz).
- `rst`, in, 1: synchronous, active-high reset.
- `locked`, in, 1: PLL lock. Asynchronous to `refclk`.
- `restart`, in, 1: single-cycle request to re-run the power sequence from READY.
- `xclk_en`, out, 1: enables the XCLK output buffer.
- `cam_pwdn`, out, 1: sensor power-down pin, active high.
- `cam_reset_n`, out, 1: sensor reset pin, active low.
- `cam_ready`, out, 1: sensor may be programmed over SCCB.
- `lock_loss_count`, out, 8: number of lock losses, saturating.

## Operation
- `locked` passes through a 2-flop synchronizer; its output is `locked_s`. The FSM uses only `locked_s`.
- FSM states and what each does:
  - WAIT_LOCK: goes to DEBOUNCE when `locked_s` is 1.
  - DEBOUNCE: counts `LOCK_STABLE_CYCLES`. Returns to WAIT_LOCK if `locked_s` drops.
  - PWDN_HOLD, RESET_HOLD, SETTLE: each counts its own dwell parameter.
  - READY: holds until a lock loss or `restart`.
- Outputs per state:
  - WAIT_LOCK and DEBOUNCE: `xclk_en`=0, `cam_pwdn`=1, `cam_reset_n`=0, `cam_ready`=0.
  - PWDN_HOLD: `xclk_en`=1, `cam_pwdn`=1, `cam_reset_n`=0.
  - RESET_HOLD: `xclk_en`=1, `cam_pwdn`=0, `cam_reset_n`=0.
  - SETTLE: `xclk_en`=1, `cam_pwdn`=0, `cam_reset_n`=1.
  - READY: as SETTLE, plus `cam_ready`=1.
- Dwell counter rules:
  - Clears on every state entry.
  - Leaves the state on the edge where count == N−1, so every timed state lasts exactly N cycles.
- Lock loss:
  - `locked_s`=0 in PWDN_HOLD, RESET_HOLD, SETTLE or READY sends the FSM to WAIT_LOCK on the next edge.
  - The same edge increments `lock_loss_count`, saturating at 255.
  - A drop during DEBOUNCE returns to WAIT_LOCK without counting.
- `restart`:
  - Honoured only in READY; sends the FSM to PWDN_HOLD. XCLK stays enabled.
  - Ignored in every other state.
- Lock loss and `restart` in the same cycle: lock loss wins and the counter increments.
- `rst`: state WAIT_LOCK, counter 0, synchronizer flops 0, `lock_loss_count` 0. Outputs take the WAIT_LOCK values (`xclk_en`=0, `cam_pwdn`=1, `cam_reset_n`=0, `cam_ready`=0).
- `rst` asserted mid-sequence takes effect on the next edge, overriding everything else.

## Timing
- All outputs are registered, decoded from the next state, so they change on the same edge as the state.
- If `locked` is high before edge k, `locked_s`=1 after edge k+1 and DEBOUNCE is entered at edge k+2.
- Sequence latency from that point:
  - PWDN_HOLD entered at edge k+2+L.
  - `cam_ready` rises at edge k+2+L+P+R+S.
  - L, P, R, S are the four dwell parameters in order.
- Lock-loss reaction: if `locked` falls before edge j, the outputs are safe after edge j+2.
- `restart` sampled at edge m: PWDN_HOLD entered and `cam_ready`=0 at edge m.

## Structure
- Shared package `ov7670_pkg` holds:
  - the state enum `pwr_state_t`;
  - constants for the default dwell counts;
  - `LOCK_LOSS_MAX` = 255.
- One sub-module, `sync_2ff`, is a generic 2-flop synchronizer reusable by other camera-domain crossings.
- The FSM, dwell counter and lock-loss counter live in the top module.

## Test plan
Parameters for all scenarios: L=4, P=3, R=5, S=2.
1. Reset, then `locked` high before edge 0: `cam_pwdn` falls at edge 9, `cam_reset_n` rises at edge 14, `cam_ready` rises at edge 16; `xclk_en`=1 from edge 6.
2. `locked` pulses high for 3 cycles only: the FSM never leaves DEBOUNCE, `xclk_en` stays 0 and `lock_loss_count`=0.
3. In READY, `locked` drops before edge j: all outputs are safe after edge j+2 and `lock_loss_count`=1. Re-lock repeats the scenario-1 timing.
4. 300 lock losses, each from READY: `lock_loss_count` saturates at 255.
5. `restart` pulse in READY: PWDN_HOLD entered on the same edge and `cam_ready` back at 1 after 10 cycles. A pulse during SETTLE is ignored. Lock loss together with `restart` in READY gives WAIT_LOCK and the counter +1.
6. `rst` asserted during RESET_HOLD: next edge gives WAIT_LOCK with all outputs at reset values and `lock_loss_count`=0.
